// File: rtl/algofoogle_product_host_if.sv
// Bundle between control logic, the product host and the multiplier pins.
// The host uses the slave view; whatever drives requests and models the multiplier uses master.
interface algofoogle_product_host_if #(
    parameter int OP_NIBBLES = 2
);
    localparam int OP_BITS  = 4 * OP_NIBBLES;
    localparam int RES_BITS = 2 * OP_BITS;

    logic [OP_BITS-1:0]  a;
    logic [OP_BITS-1:0]  b;
    logic                start;
    logic                busy;
    logic                done;
    logic [RES_BITS-1:0] result;
    logic                link_reset;
    logic [3:0]          link_nibble;
    logic [7:0]          link_byte;

    modport slave (
        input  a, b, start, link_byte,
        output busy, done, result, link_reset, link_nibble
    );

    modport master (
        output a, b, start, link_byte,
        input  busy, done, result, link_reset, link_nibble
    );
endinterface

// File: rtl/algofoogle_product_host.sv
// Host-side sequencer for the algofoogle_product nibble-serial multiplier:
// streams operand nibbles MS first, collects product bytes MS first, presents the product.
module algofoogle_product_host #(
    parameter int OP_NIBBLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    algofoogle_product_host_if.slave    bus
);
    localparam int OP_BITS  = 4 * OP_NIBBLES;
    localparam int RES_BITS = 2 * OP_BITS;
    localparam logic [2:0] K_NIB_LAST  = 3'(2 * OP_NIBBLES - 1);
    localparam logic [2:0] K_BYTE_LAST = 3'(OP_NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_NIB, S_CALC, S_BYTE} state_t;

    // NOTE: assert asynchronously, release on a clock edge so every flop leaves reset in the same cycle.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rst_sync <= 2'b11;
        else       r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
    assign w_rst = r_rst_sync[1];

    state_t              r_state, w_state_next;
    logic [2:0]          r_k, w_k_next;
    logic [RES_BITS-1:0] r_shift, w_shift_next;
    logic [RES_BITS-1:0] r_acc, w_acc_next;
    logic [RES_BITS-1:0] r_result;
    logic                r_busy, r_done, r_link_reset;
    logic [3:0]          r_link_nibble;
    logic                w_last_byte;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_shift_next = r_shift;
        w_acc_next   = r_acc;
        w_last_byte  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_NIB;
                    w_k_next     = 3'd0;
                    w_shift_next = {bus.a, bus.b};
                end
            end
            S_NIB: begin
                w_shift_next = r_shift << 4;
                if (r_k == K_NIB_LAST) begin
                    w_state_next = S_CALC;
                    w_k_next     = 3'd0;
                end else begin
                    w_k_next = r_k + 3'd1;
                end
            end
            S_CALC: begin
                w_state_next = S_BYTE;
                w_k_next     = 3'd0;
            end
            S_BYTE: begin
                w_acc_next[RES_BITS-1-8*int'(r_k) -: 8] = bus.link_byte;
                if (r_k == K_BYTE_LAST) begin
                    w_state_next = S_IDLE;
                    w_k_next     = 3'd0;
                    w_last_byte  = 1'b1;
                end else begin
                    w_k_next = r_k + 3'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state       <= S_IDLE;
            r_k           <= 3'd0;
            r_shift       <= '0;
            r_acc         <= '0;
            r_result      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_link_reset  <= 1'b1;
            r_link_nibble <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_k           <= w_k_next;
            r_shift       <= w_shift_next;
            r_acc         <= w_acc_next;
            r_busy        <= (w_state_next != S_IDLE);
            r_done        <= w_last_byte;
            r_link_reset  <= (w_state_next == S_IDLE);
            r_link_nibble <= (w_state_next == S_NIB) ? w_shift_next[RES_BITS-1 -: 4] : 4'd0;
            if (w_last_byte) r_result <= w_acc_next;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.link_reset  = r_link_reset;
    assign bus.link_nibble = r_link_nibble;
endmodule

// File: tb/tb_algofoogle_product_host.sv
// Directed bench for algofoogle_product_host with a small behavioural multiplier on the link pins.
module tb_algofoogle_product_host;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    algofoogle_product_host_if #(.OP_NIBBLES(N)) bus ();

    algofoogle_product_host #(.OP_NIBBLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Multiplier model: nibbles in states 0..3, multiply in 4, bytes out MS first in 5..6, then wrap.
    logic [3:0]  m_s;
    logic [15:0] m_op;
    logic [15:0] m_p;

    always @(posedge clk) begin
        if (bus.link_reset) begin
            m_s  <= 4'd0;
            m_op <= 16'd0;
            m_p  <= 16'd0;
        end else begin
            if (m_s < 4'd4) m_op <= {m_op[11:0], bus.link_nibble};
            if (m_s == 4'd4) m_p <= 16'(m_op[15:8] * m_op[7:0]);
            m_s <= (m_s == 4'd6) ? 4'd0 : m_s + 4'd1;
        end
    end

    assign bus.link_byte = (m_s == 4'd5) ? m_p[15:8] :
                           (m_s == 4'd6) ? m_p[7:0]  : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start with the given operands and wait (bounded) for done; done lands in cycle 8.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [15:0] exp, input string tag);
        int n;
        bus.a = ta; bus.b = tb_v; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 8);
        check({tag, " result"}, bus.result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n_done;
        logic [3:0] exp_nib [1:4];
        exp_nib[1] = 4'h1; exp_nib[2] = 4'h2; exp_nib[3] = 4'h3; exp_nib[4] = 4'h4;

        reset = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) tick();
        check("rst link_reset", bus.link_reset, 1);
        check("rst busy", bus.busy, 0);
        reset = 1'b0;
        repeat (4) tick();

        // Idle after reset: all outputs at rest values.
        for (int i = 0; i < 5; i++) begin
            check("idle link_reset", bus.link_reset, 1);
            check("idle link_nibble", bus.link_nibble, 0);
            check("idle busy", bus.busy, 0);
            check("idle done", bus.done, 0);
            check("idle result", bus.result, 0);
            tick();
        end

        // 0x12 * 0x34 with the full cycle map checked.
        bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.start = 1'b0;
            check("map busy", bus.busy, (c <= 7) ? 1 : 0);
            check("map done", bus.done, (c == 8) ? 1 : 0);
            check("map link_reset", bus.link_reset, (c >= 5 && c <= 7) ? 0 : ((c <= 4) ? 0 : 1));
            if (c <= 4) check("map nibble", bus.link_nibble, exp_nib[c]);
            if (c == 5) check("calc nibble", bus.link_nibble, 0);
            if (c == 6) check("byte hi", bus.link_byte, 8'h03);
            if (c == 7) check("byte lo", bus.link_byte, 8'hA8);
            if (c == 7) check("result before done", bus.result, 0);
            if (c == 8) check("map result", bus.result, 16'h03A8);
        end
        tick();
        check("done one cycle", bus.done, 0);

        // Extremes, then check the old result holds while the next op runs.
        do_op(8'hFF, 8'hFF, 16'hFE01, "ffxff");
        tick();
        bus.a = 8'h00; bus.b = 8'h7B; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("hold result", bus.result, 16'hFE01);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) n_done++;
            tick();
        end
        check("zero op dones", n_done, 1);
        check("zero result", bus.result, 16'h0000);

        // Start held high: second op is accepted in the done cycle, 3N+2 cycles between done pulses.
        bus.a = 8'h0F; bus.b = 8'h10; bus.start = 1'b1;
        tick();
        bus.a = 8'hA5; bus.b = 8'h02;
        repeat (7) tick();
        check("b2b done1", bus.done, 1);
        check("b2b result1", bus.result, 16'h00F0);
        repeat (7) tick();
        check("b2b busy mid", bus.busy, 1);
        check("b2b no early done", bus.done, 0);
        tick();
        check("b2b done2", bus.done, 1);
        check("b2b result2", bus.result, 16'h014A);
        bus.start = 1'b0;
        tick();
        check("b2b idle", bus.busy, 0);

        // Start during busy is ignored.
        bus.a = 8'h1B; bus.b = 8'h0C; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) n_done++;
            tick();
        end
        check("ignore dones", n_done, 1);
        check("ignore result", bus.result, 16'h0144);

        // Reset in cycle 6 aborts at once with no done.
        bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort link_reset", bus.link_reset, 1);
        check("abort result", bus.result, 0);
        repeat (2) tick();
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) n_done++;
            tick();
        end
        check("abort no done", n_done, 0);
        do_op(8'h03, 8'h05, 16'h000F, "after abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
